// File: rtl/mem_stage_ctrl.sv
// Memory-access stage controller: issues data-memory requests over a req/ack
// handshake, stalls upstream while an access is outstanding, bounds the wait
// with a timeout that sets a sticky error, and registers the write-back bundle.
module mem_stage_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [4:0]  RDM,
  input  logic [18:0] ALUResultM,
  input  logic [18:0] WriteDataM,
  input  logic        Cant_ByteM,
  input  logic [18:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        dmem_byte,
  output logic [14:0] dmem_addr,
  output logic [18:0] dmem_wdata,
  output logic        stall_m,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [4:0]  RDW,
  output logic [18:0] ALUResultW,
  output logic [18:0] ReadDataW,
  output logic        mem_err
);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e      state_q;
  logic [7:0]  wait_cnt_q;

  logic        access;
  logic        is_load;
  logic        in_req;
  logic        timeout;
  logic [18:0] load_data;

  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  // Decode the M bundle and the handshake conditions.
  always_comb begin
    access    = MemWriteM | (ResultSrcM == 2'b01);
    // A store that also claims a load result is treated as a plain store.
    is_load   = (ResultSrcM == 2'b01) & ~MemWriteM;
    in_req    = (state_q == StReq);
    timeout   = in_req & ~dmem_ack & (wait_cnt_q == WaitLast);
    load_data = 19'd0;
    if (is_load) begin
      load_data = Cant_ByteM ? {11'd0, dmem_rdata[7:0]} : dmem_rdata;
    end
  end

  // Memory-side outputs and stall; everything reads 0 while reset is held.
  always_comb begin
    dmem_req   = in_req;
    dmem_we    = in_req & MemWriteM;
    dmem_byte  = in_req & Cant_ByteM;
    dmem_addr  = reset ? ALUResultM[14:0] : 15'd0;
    dmem_wdata = 19'd0;
    if (reset) begin
      dmem_wdata = Cant_ByteM ? {11'd0, WriteDataM[7:0]} : WriteDataM;
    end
    stall_m = reset & (((state_q == StIdle) & access) | (in_req & ~dmem_ack & ~timeout));
  end

  // FSM, wait counter, sticky error and write-back register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= 8'd0;
      mem_err    <= 1'b0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      RDW        <= 5'd0;
      ALUResultW <= 19'd0;
      ReadDataW  <= 19'd0;
    end else begin
      // Default W contents are a bubble; overridden when an instruction retires.
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      RDW        <= 5'd0;
      ALUResultW <= 19'd0;
      ReadDataW  <= 19'd0;
      unique case (state_q)
        StIdle: begin
          if (access) begin
            state_q    <= StReq;
            wait_cnt_q <= 8'd0;
          end else begin
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            RDW        <= RDM;
            ALUResultW <= ALUResultM;
          end
        end
        StReq: begin
          if (dmem_ack) begin
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            RDW        <= RDM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= load_data;
            state_q    <= StIdle;
          end else if (timeout) begin
            mem_err <= 1'b1;
            state_q <= StIdle;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: a small memory responder plus a
// scoreboard of expected write-back bundles.
module tb_mem_stage_ctrl;

  localparam int unsigned Timeout = 4;

  logic        clk;
  logic        reset;
  logic        RegWriteM, MemWriteM, Cant_ByteM, dmem_ack;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RDM;
  logic [18:0] ALUResultM, WriteDataM, dmem_rdata;
  logic        dmem_req, dmem_we, dmem_byte, stall_m, RegWriteW, mem_err;
  logic [14:0] dmem_addr;
  logic [18:0] dmem_wdata, ALUResultW, ReadDataW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RDW;

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [18:0] alu;
    logic [18:0] rdata;
  } wb_t;

  wb_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  logic exp_err = 1'b0;

  mem_stage_ctrl #(.MEM_TIMEOUT(Timeout)) dut (
    .clk(clk), .reset(reset),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RDM(RDM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .Cant_ByteM(Cant_ByteM),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_byte(dmem_byte),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .stall_m(stall_m),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RDW(RDW),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one instruction into M (called just after a clock edge), respond to
  // its memory request after ack_after REQ cycles (-1 = never) and check W.
  task automatic issue(input logic rw, input logic mw, input logic [1:0] rs,
                       input logic [4:0] rd, input logic [18:0] alu,
                       input logic [18:0] wd, input logic bt,
                       input int ack_after, input logic [18:0] rdata);
    wb_t e;
    wb_t got;
    logic is_mem, is_load, done;
    int stall_cnt, req_cnt, cycles;
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RDM = rd;
    ALUResultM = alu; WriteDataM = wd; Cant_ByteM = bt;
    is_mem  = mw | (rs == 2'b01);
    is_load = (rs == 2'b01) & ~mw;
    if (is_mem && ack_after < 0) begin
      e = '{rw: 1'b0, rs: 2'b00, rd: 5'd0, alu: 19'd0, rdata: 19'd0};
      exp_err = 1'b1;
    end else begin
      e = '{rw: rw, rs: rs, rd: rd, alu: alu, rdata: 19'd0};
      if (is_load) e.rdata = bt ? {11'd0, rdata[7:0]} : rdata;
    end
    exp_q.push_back(e);
    stall_cnt = 0; req_cnt = 0; cycles = 0; done = 1'b0;
    while (!done && cycles < 50) begin
      dmem_ack   = dmem_req && (ack_after >= 0) && (req_cnt == ack_after);
      dmem_rdata = dmem_ack ? rdata : 19'h2AAAA;
      #1;
      if (dmem_req) begin
        check("addr", 32'(dmem_addr), 32'(alu[14:0]));
        check("we", 32'(dmem_we), 32'(mw));
        check("byte", 32'(dmem_byte), 32'(bt));
        check("wdata", 32'(dmem_wdata), bt ? 32'(wd[7:0]) : 32'(wd));
        req_cnt++;
      end
      if (cycles > 0) check("bubble_rw", 32'(RegWriteW), 32'd0);
      if (stall_m) stall_cnt++;
      done = !stall_m;
      @(posedge clk); #1;
      cycles++;
    end
    dmem_ack = 1'b0;
    check("done_in_bound", 32'(done), 32'd1);
    check("stall_cycles", 32'(stall_cnt),
          !is_mem ? 32'd0 : (ack_after < 0 ? 32'(Timeout) : 32'(1 + ack_after)));
    check("req_cycles", 32'(req_cnt),
          !is_mem ? 32'd0 : (ack_after < 0 ? 32'(Timeout) : 32'(ack_after + 1)));
    got = exp_q.pop_front();
    check("RegWriteW", 32'(RegWriteW), 32'(got.rw));
    check("ResultSrcW", 32'(ResultSrcW), 32'(got.rs));
    check("RDW", 32'(RDW), 32'(got.rd));
    check("ALUResultW", 32'(ALUResultW), 32'(got.alu));
    check("ReadDataW", 32'(ReadDataW), 32'(got.rdata));
    check("mem_err", 32'(mem_err), 32'(exp_err));
  endtask

  initial begin
    reset = 1'b0; dmem_ack = 1'b0; dmem_rdata = 19'd0;
    RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 2'b00; RDM = 5'd0;
    ALUResultM = 19'd0; WriteDataM = 19'd0; Cant_ByteM = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(stall_m), 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);
    check("rst_rw", 32'(RegWriteW), 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // ALU op, word load, byte store, byte load, store+load combo
    issue(1'b1, 1'b0, 2'b00, 5'd5, 19'h12345, 19'h0, 1'b0, 0, 19'h0);
    issue(1'b1, 1'b0, 2'b01, 5'd7, 19'h00040, 19'h0, 1'b0, 0, 19'h7ABCD);
    issue(1'b0, 1'b1, 2'b00, 5'd0, 19'h00123, 19'h5A3C7, 1'b1, 3, 19'h0);
    issue(1'b1, 1'b0, 2'b01, 5'd9, 19'h7C080, 19'h0, 1'b1, 1, 19'h7FFFF);
    issue(1'b1, 1'b1, 2'b01, 5'd3, 19'h00200, 19'h11111, 1'b0, 0, 19'h55555);
    // Timeout, then a normal ALU op and back-to-back loads with mem_err sticky
    issue(1'b1, 1'b0, 2'b01, 5'd4, 19'h00300, 19'h0, 1'b0, -1, 19'h0);
    issue(1'b1, 1'b0, 2'b10, 5'd6, 19'h0ABCD, 19'h0, 1'b0, 0, 19'h0);
    issue(1'b1, 1'b0, 2'b01, 5'd1, 19'h00010, 19'h0, 1'b0, 2, 19'h3C3C3);
    issue(1'b1, 1'b0, 2'b01, 5'd2, 19'h00011, 19'h0, 1'b1, 0, 19'h1F0A5);

    // Reset during the second REQ cycle of a load
    RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b01; RDM = 5'd8;
    ALUResultM = 19'h00444; Cant_ByteM = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_req_before", 32'(dmem_req), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_req", 32'(dmem_req), 32'd0);
    check("mid_rst_stall", 32'(stall_m), 32'd0);
    check("mid_rst_err", 32'(mem_err), 32'd0);
    check("mid_rst_wdata", 32'(dmem_wdata), 32'd0);
    exp_err = 1'b0;
    RegWriteM = 1'b0; ResultSrcM = 2'b00;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 2'b01, 5'd8, 19'h00444, 19'h0, 1'b0, 1, 19'h6D6D6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-access stage of the 19-bit pipelined core. It consumes the M-stage bundle latched by the execute stage, performs loads and stores against the data memory over a req/ack handshake, stalls the upstream pipeline while an access is outstanding, and registers the write-back bundle. Word and byte accesses are selected by the byte-size control carried down from decode, and a bounded wait turns a missing `ack` into a sticky error instead of a hang.

## Interface
- `MEM_TIMEOUT`, default 15: maximum cycles in REQ without `dmem_ack` before abort. Legal range 1–255.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low.
- `RegWriteM`  in  1  instruction writes the register file.
- `MemWriteM`  in  1  instruction is a store.
- `ResultSrcM`  in  2  write-back select. 01 means load; other codes are passed through.
- `RDM`  in  5  destination register.
- `ALUResultM`  in  19  effective address or ALU result.
- `WriteDataM`  in  19  store data.
- `Cant_ByteM`  in  1  1 selects a byte access (bits [7:0]); 0 selects a full 19-bit word.
- `dmem_rdata`  in  19  read data, valid only in the cycle `dmem_ack`=1.
- `dmem_ack`  in  1  memory completion pulse.
- `dmem_req`  out  1  access request.
- `dmem_we`  out  1  1 = write.
- `dmem_byte`  out  1  byte-lane access.
- `dmem_addr`  out  15  equals `ALUResultM[14:0]`.
- `dmem_wdata`  out  19  store data. In byte mode this is `{11'b0, WriteDataM[7:0]}`.
- `stall_m`  out  1  freezes the F/D/E pipeline registers and holds the M-stage inputs stable.
- `RegWriteW`, `ResultSrcW[1:0]`, `RDW[4:0]`, `ALUResultW[18:0]`, `ReadDataW[18:0]`  out  write-back register outputs.
- `mem_err`  out  1  sticky timeout flag.

## Operation
- `access` = `MemWriteM` | (`ResultSrcM`==2'b01). It is evaluated only in IDLE.
- The FSM has two states, IDLE and REQ. Reset enters IDLE.
- **IDLE, `access`=0.** `stall_m`=0. The W register captures the M bundle on the next edge, with `ReadDataW`=0.
- **IDLE, `access`=1.** `stall_m`=1. The W register loads a bubble: `RegWriteW`=0 and all other W fields 0. The FSM moves to REQ, and the wait counter clears to 0.
- **REQ, signal outputs.** `dmem_req`=1. `dmem_we`=`MemWriteM` and `dmem_byte`=`Cant_ByteM`. The address and data outputs are driven from the M inputs, which `stall_m` holds stable.
- **REQ, no `ack`.** `stall_m`=1, the counter increments, and the W register takes a bubble.
- **REQ, `ack`=1.**
  - `stall_m`=0 in this same cycle.
  - On the edge, the W register captures the M bundle. `ReadDataW` is `dmem_rdata` for a word load, `{11'b0, dmem_rdata[7:0]}` for a byte load, and 0 for a store.
  - The FSM returns to IDLE.
- **REQ, timeout.** When the counter reaches `MEM_TIMEOUT-1` with no `ack`:
  - On the next edge `mem_err` is set, the W register takes a bubble, and the FSM goes to IDLE.
  - `stall_m`=0 in that cycle, so the instruction is dropped.
- `mem_err` clears only on reset.
- `dmem_req`, `dmem_we` and `dmem_byte` are 0 whenever the FSM is not in REQ. `dmem_addr` and `dmem_wdata` follow the inputs in every state.
- Both `MemWriteM`=1 and `ResultSrcM`=01 is treated as a store, and `ReadDataW`=0.

## Timing
- Non-memory instruction: 1 cycle through the stage, no stall.
- Memory access latency is 1 (IDLE detect) + k cycles, where k ≥ 1 is the number of REQ cycles up to and including `ack`. Minimum: a 2-cycle stall window, with the result visible in W 2 edges after the instruction enters M.
- Maximum occupancy on timeout: 1 + `MEM_TIMEOUT` cycles.
- `dmem_ack` is ignored outside REQ. `dmem_req` deasserts on the edge after `ack`, so there are no back-to-back `req` cycles for one instruction.
- Consecutive memory instructions pass through IDLE for one cycle each.
- Reset is asynchronous and may occur mid-access. All outputs immediately go to 0: `dmem_*`, `stall_m`, every W field, and `mem_err`. The FSM returns to IDLE and the counter to 0. The abandoned access is not retried.

## Test plan
- **ALU op passes through.** `RegWriteM`=1, `ResultSrcM`=00, `RDM`=5, `ALUResultM`=19'h12345. Required: `stall_m` never 1; next edge `RegWriteW`=1, `RDW`=5, `ALUResultW`=19'h12345.
- **Word load, ack in first REQ cycle.** Load with `ALUResultM`=0x0040 and `dmem_rdata`=19'h7ABCD. Required: `dmem_req` high for exactly 1 cycle with `dmem_addr`=0x0040 and `dmem_we`=0; `stall_m` high for 1 cycle; `ReadDataW`=19'h7ABCD.
- **Byte store, ack after 3 REQ cycles.** `WriteDataM`=19'h5A3C7, `Cant_ByteM`=1. Required: `dmem_wdata`=19'h000C7, `dmem_byte`=1, `dmem_we`=1; `stall_m` high for 4 cycles; W shows a bubble (`RegWriteW`=0) during the stall.
- **Byte load zero-extends.** `dmem_rdata`=19'h7FFFF with `Cant_ByteM`=1. Required: `ReadDataW`=19'h000FF.
- **Timeout.** `MEM_TIMEOUT`=4 and no `ack`. Required: `dmem_req` high for 4 cycles then low; `mem_err`=1 and it stays set; `RegWriteW`=0; the following ALU op completes normally.
- **Reset mid-REQ.** Assert `reset`=0 in the 2nd REQ cycle. Required: `dmem_req`, `stall_m` and `mem_err` are 0 at once; after release, a new load completes normally.
